// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage RV32 pipeline: EX/MEM/WB
// destination scoreboard, operand forward select, load-use stall and redirect flush.
module pipe_hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic             id_have_inst,
   input  logic             id_rf_we,
   input  logic [4:0]       id_wR,
   input  logic             id_is_load,
   input  logic             ex_redirect,
   input  logic             clr_cnt,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic [1:0]       fwd_sel1,
   output logic [1:0]       fwd_sel2,
   output logic             forward_op1,
   output logic             forward_op2,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             in_stall
);

   typedef struct packed {
      logic       we;
      logic [4:0] rd;
      logic       ld;
   } slot_t;

   typedef enum logic {RUN, LU_STALL} state_t;

   slot_t            r_ex, r_mem, r_wb;
   state_t           r_state;
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

   logic       w_ex1, w_ex2, w_hazard, w_stall, w_bubble;
   logic [1:0] w_sel1, w_sel2;
   logic       w_unused;

   function automatic logic hit(input slot_t s, input logic [4:0] r, input logic used);
      return used && s.we && (s.rd == r) && (r != 5'd0);
   endfunction

   // Youngest producer wins; a load still in EX has no data yet, so it forwards nothing.
   function automatic logic [1:0] pick(input slot_t ex, input slot_t mem, input slot_t wb,
                                       input logic [4:0] r, input logic used);
      if (hit(ex, r, used))       return ex.ld ? 2'b00 : 2'b01;
      else if (hit(mem, r, used)) return 2'b10;
      else if (hit(wb, r, used))  return 2'b11;
      else                        return 2'b00;
   endfunction

   assign w_ex1    = hit(r_ex, id_rs1, id_rs1_used);
   assign w_ex2    = hit(r_ex, id_rs2, id_rs2_used);
   assign w_hazard = id_have_inst && r_ex.ld && (w_ex1 || w_ex2);
   assign w_stall  = w_hazard && !ex_redirect;
   assign w_bubble = w_stall || ex_redirect;
   assign w_sel1   = pick(r_ex, r_mem, r_wb, id_rs1, id_rs1_used);
   assign w_sel2   = pick(r_ex, r_mem, r_wb, id_rs2, id_rs2_used);

   // is_load only matters in EX; the older slots carry it for debug visibility.
   assign w_unused = ^{r_mem.ld, r_wb.ld};

   assign pc_stall    = w_stall;
   assign if_id_stall = w_stall;
   assign if_id_flush = ex_redirect;
   assign id_ex_flush = w_bubble;
   assign fwd_sel1    = w_bubble ? 2'b00 : w_sel1;
   assign fwd_sel2    = w_bubble ? 2'b00 : w_sel2;
   assign forward_op1 = (fwd_sel1 != 2'b00);
   assign forward_op2 = (fwd_sel2 != 2'b00);
   assign stall_cnt   = r_stall_cnt;
   assign flush_cnt   = r_flush_cnt;
   assign in_stall    = (r_state == LU_STALL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex    <= '0;
         r_mem   <= '0;
         r_wb    <= '0;
         r_state <= RUN;
      end else begin
         r_wb  <= r_mem;
         r_mem <= r_ex;
         r_ex  <= w_bubble ? slot_t'('0) : slot_t'({id_have_inst & id_rf_we, id_wR, id_is_load});
         case (r_state)
            RUN:      r_state <= w_stall ? LU_STALL : RUN;
            LU_STALL: r_state <= RUN;
            default:  r_state <= RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (clr_cnt) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall && !(&r_stall_cnt))     r_stall_cnt <= r_stall_cnt + 1'b1;
         if (ex_redirect && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding, load-use stall, redirect,
// x0, counter saturation/clear and reset mid-stall, with CNT_W=4.
module tb_pipe_hazard_ctrl;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [4:0]       rs1, rs2, wr;
   logic             u1, u2, hv, we, ld, redir, clr;
   logic             pc_stall, if_id_stall, if_id_flush, id_ex_flush;
   logic [1:0]       sel1, sel2;
   logic             fop1, fop2, in_stall;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(rs1), .id_rs2(rs2), .id_rs1_used(u1), .id_rs2_used(u2),
      .id_have_inst(hv), .id_rf_we(we), .id_wR(wr), .id_is_load(ld),
      .ex_redirect(redir), .clr_cnt(clr),
      .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
      .id_ex_flush(id_ex_flush), .fwd_sel1(sel1), .fwd_sel2(sel2),
      .forward_op1(fop1), .forward_op2(fop2),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .in_stall(in_stall)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      rs1 = 5'd0; rs2 = 5'd0; wr = 5'd0;
      u1 = 1'b0; u2 = 1'b0; hv = 1'b0; we = 1'b0; ld = 1'b0;
      redir = 1'b0; clr = 1'b0;
   endtask

   task automatic drain();
      idle_in();
      repeat (3) tick();
   endtask

   task automatic producer(input logic [4:0] rd, input logic is_ld);
      idle_in();
      hv = 1'b1; we = 1'b1; wr = rd; ld = is_ld;
   endtask

   initial begin
      idle_in();
      rst_n = 1'b0;
      #3;
      chk("rst_pc_stall", pc_stall, 0);
      chk("rst_ctl", {if_id_stall, if_id_flush, id_ex_flush, fop1, fop2}, 0);
      chk("rst_sel", {sel1, sel2}, 0);
      chk("rst_cnt", {stall_cnt, flush_cnt}, 0);
      chk("rst_in_stall", in_stall, 0);
      redir = 1'b1;
      #1;
      chk("rst_redir_flush", {if_id_flush, id_ex_flush, pc_stall, if_id_stall}, 4'b1100);
      redir = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // ALU producer followed by dependent consumer
      producer(5'd5, 1'b0);
      tick();
      idle_in(); hv = 1'b1; we = 1'b1; wr = 5'd8; u1 = 1'b1; rs1 = 5'd5;
      #1;
      chk("alu_sel1", sel1, 2'b01);
      chk("alu_fop1", fop1, 1);
      chk("alu_sel2", sel2, 2'b00);
      chk("alu_nostall", pc_stall, 0);
      tick();
      chk("alu_stall_cnt", stall_cnt, 0);
      drain();

      // load-use: one bubble, then MEM forwarding
      producer(5'd6, 1'b1);
      tick();
      idle_in(); hv = 1'b1; we = 1'b1; wr = 5'd9; u2 = 1'b1; rs2 = 5'd6;
      #1;
      chk("lu_stall", {pc_stall, if_id_stall, id_ex_flush}, 3'b111);
      chk("lu_sel2_forced", sel2, 2'b00);
      chk("lu_if_id_flush", if_id_flush, 0);
      tick();
      chk("lu_in_stall", in_stall, 1);
      chk("lu_release", {pc_stall, if_id_stall, id_ex_flush}, 3'b000);
      chk("lu_sel2_mem", sel2, 2'b10);
      chk("lu_fop2", fop2, 1);
      chk("lu_stall_cnt", stall_cnt, 1);
      tick();
      chk("lu_back_run", in_stall, 0);
      drain();

      // x7 in all three slots, then with younger slots emptied
      producer(5'd7, 1'b0);
      repeat (3) tick();
      idle_in(); hv = 1'b1; u1 = 1'b1; u2 = 1'b1; rs1 = 5'd7; rs2 = 5'd7;
      #1;
      chk("pri_ex_sel1", sel1, 2'b01);
      chk("pri_ex_sel2", sel2, 2'b01);
      tick();
      chk("pri_mem_sel1", sel1, 2'b10);
      tick();
      chk("pri_wb_sel1", sel1, 2'b11);
      chk("pri_wb_fop1", fop1, 1);
      drain();

      // load-use coinciding with redirect
      producer(5'd10, 1'b1);
      tick();
      idle_in(); hv = 1'b1; we = 1'b1; wr = 5'd11; u1 = 1'b1; rs1 = 5'd10; redir = 1'b1;
      #1;
      chk("rdr_flush", {if_id_flush, id_ex_flush}, 2'b11);
      chk("rdr_nostall", {pc_stall, if_id_stall}, 2'b00);
      chk("rdr_sel1", sel1, 2'b00);
      tick();
      redir = 1'b0;
      #1;
      chk("rdr_flush_cnt", flush_cnt, 1);
      chk("rdr_stall_cnt", stall_cnt, 1);
      chk("rdr_in_stall", in_stall, 0);
      chk("rdr_load_in_mem", sel1, 2'b10);
      rs1 = 5'd11;
      #1;
      chk("rdr_ex_empty", sel1, 2'b00);
      drain();

      // x0 never forwards or stalls
      producer(5'd0, 1'b0);
      tick();
      idle_in(); hv = 1'b1; u1 = 1'b1; u2 = 1'b1;
      #1;
      chk("x0_sel", {sel1, sel2}, 4'b0000);
      chk("x0_nostall", pc_stall, 0);
      drain();
      producer(5'd0, 1'b1);
      tick();
      idle_in(); hv = 1'b1; u1 = 1'b1; u2 = 1'b1;
      #1;
      chk("x0_load_nostall", {pc_stall, id_ex_flush}, 2'b00);
      drain();

      // 20 more load-use stalls saturate the 4-bit counter
      for (int i = 0; i < 20; i++) begin
         producer(5'd12, 1'b1);
         tick();
         idle_in(); hv = 1'b1; u1 = 1'b1; rs1 = 5'd12;
         tick();
         tick();
      end
      chk("sat_stall_cnt", stall_cnt, 15);
      chk("sat_flush_cnt", flush_cnt, 1);

      // clear beats a concurrent redirect increment
      idle_in(); clr = 1'b1; redir = 1'b1;
      tick();
      idle_in();
      #1;
      chk("clr_cnt", {stall_cnt, flush_cnt}, 8'h00);

      // reset asserted mid-stall
      producer(5'd13, 1'b1);
      tick();
      idle_in(); hv = 1'b1; u1 = 1'b1; rs1 = 5'd13;
      tick();
      chk("mid_in_stall", in_stall, 1);
      chk("mid_stall_cnt", stall_cnt, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_stall", in_stall, 0);
      chk("mid_rst_cnt", stall_cnt, 0);
      chk("mid_rst_ctl", {pc_stall, id_ex_flush, sel1}, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("post_rst_nostall", {pc_stall, in_stall}, 2'b00);
      chk("post_rst_sel1", sel1, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
